// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: enable loads a valid instruction, flush inserts a bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc4_d,
  output logic [XLEN-1:0] instr_q,
  output logic [XLEN-1:0] pc4_q,
  output logic            valid_q
);

  logic [XLEN-1:0] instr_nxt;
  logic [XLEN-1:0] pc4_nxt;
  logic            valid_nxt;

  // Flush only clears valid; the stale payload is harmless behind valid=0.
  always_comb begin
    instr_nxt = instr_q;
    pc4_nxt   = pc4_q;
    valid_nxt = valid_q;
    if (flush) begin
      valid_nxt = 1'b0;
    end else if (en) begin
      instr_nxt = instr_d;
      pc4_nxt   = pc4_d;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= INSTR_NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_nxt;
      pc4_q   <= pc4_nxt;
      valid_q <= valid_nxt;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, IF/ID load control.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_buf_q, hold_buf_d;
  logic            kill_q, kill_d;

  logic            ifid_en;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_instr;
  logic            resp_done;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign resp_done = (state_q == S_WAIT) && imem_rvalid && !kill_q;
  assign fetch_busy = (state_q != S_HOLD) && !resp_done;
  assign ifid_instr = (state_q == S_HOLD) ? hold_buf_q : imem_rdata;

  // Next-state and IF/ID control; redirect overrides stall and completion.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_buf_d = hold_buf_q;
    kill_d     = kill_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    if (redirect) begin
      pc_d       = pc_next;
      ifid_flush = 1'b1;
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: begin
          state_d    = S_REQ;
          hold_buf_d = '0;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) state_d = S_WAIT;
          ifid_flush = !stall;
        end
        S_WAIT: begin
          if (imem_rvalid && kill_q) begin
            kill_d     = 1'b0;
            state_d    = S_REQ;
            ifid_flush = !stall;
          end else if (imem_rvalid && !stall) begin
            ifid_en = 1'b1;
            pc_d    = pc_next;
            state_d = S_REQ;
          end else if (imem_rvalid) begin
            hold_buf_d = imem_rdata;
            state_d    = S_HOLD;
          end else begin
            ifid_flush = !stall;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_en = 1'b1;
            pc_d    = pc_next;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      hold_buf_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_buf_q <= hold_buf_d;
      kill_q     <= kill_d;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ifid_en),
    .flush   (ifid_flush),
    .instr_d (ifid_instr),
    .pc4_d   (pc_plus4),
    .instr_q (if_id_instr),
    .pc4_q   (if_id_pc4),
    .valid_q (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset sequence, random run vs. model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        redirect;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_busy;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_next     (pc_next),
    .redirect    (redirect),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Directed vector: inputs for one cycle, pre-edge combinational and post-edge registered expectations.
  typedef struct {
    logic        stall;
    logic        redirect;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] pc_next;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic rd, input logic rdy, input logic rv,
                              input logic [31:0] data, input logic [31:0] nxt,
                              input logic req, input logic [31:0] addr, input logic busy,
                              input logic [31:0] epc, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep4);
    vec_t v;
    v.stall = st; v.redirect = rd; v.ready = rdy; v.rvalid = rv;
    v.rdata = data; v.pc_next = nxt;
    v.e_req = req; v.e_addr = addr; v.e_busy = busy;
    v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep4;
    return v;
  endfunction

  // Transaction-level reference: outstanding flag, kill pending, held-word queue.
  logic [31:0] m_pc;
  bit          m_out, m_kill;
  logic [31:0] m_held[$];
  logic        e_valid;
  logic [31:0] e_instr, e_pc4;
  bit          mem_pend;
  int          mem_cnt;

  function automatic bit m_req();
    return !m_out && (m_held.size() == 0);
  endfunction

  task automatic m_load(input logic [31:0] word);
    e_instr = word;
    e_pc4   = m_pc + 32'd4;
    e_valid = 1'b1;
    m_pc    = pc_next;
  endtask

  task automatic m_step();
    bit acc, resp;
    acc  = m_req() && imem_ready;
    resp = m_out && imem_rvalid;
    if (redirect) begin
      m_pc    = pc_next;
      e_valid = 1'b0;
      if (acc) begin
        m_out = 1; m_kill = 1;
      end else if (resp) begin
        m_out = 0; m_kill = 0;
      end else if (m_out) begin
        m_kill = 1;
      end
      m_held.delete();
    end else begin
      if (acc) m_out = 1;
      if (resp) begin
        m_out = 0;
        if (m_kill) begin
          m_kill = 0;
          if (!stall) e_valid = 1'b0;
        end else if (!stall) begin
          m_load(imem_rdata);
        end else begin
          m_held.push_back(imem_rdata);
        end
      end else if (m_held.size() != 0 && !stall) begin
        m_load(m_held.pop_front());
      end else if (!stall) begin
        e_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_next = '0; redirect = 0; stall = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;

    // s=stall r=redirect rdy rv rdata pc_next | req addr busy | pc valid instr pc4
    vecs.push_back(mk(0,0,1,0,32'h0,        32'h0,  1,32'h0, 1, 32'h0, 0,32'h0,        32'h0));
    vecs.push_back(mk(0,0,0,1,32'h2002_0005,32'h4,  0,32'h0, 0, 32'h4, 1,32'h2002_0005,32'h4));
    vecs.push_back(mk(0,0,1,0,32'h0,        32'h8,  1,32'h4, 1, 32'h4, 0,32'h2002_0005,32'h4));
    vecs.push_back(mk(1,0,0,1,32'h1111_1111,32'h8,  0,32'h4, 0, 32'h4, 0,32'h2002_0005,32'h4));
    vecs.push_back(mk(1,0,0,0,32'h0,        32'h8,  0,32'h4, 0, 32'h4, 0,32'h2002_0005,32'h4));
    vecs.push_back(mk(1,0,0,0,32'h0,        32'h8,  0,32'h4, 0, 32'h4, 0,32'h2002_0005,32'h4));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h8,  0,32'h4, 0, 32'h8, 1,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,0,1,0,32'h0,        32'hC,  1,32'h8, 1, 32'h8, 0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h40, 0,32'h8, 1, 32'h40,0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h44, 0,32'h40,1, 32'h40,0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,0,0,1,32'hDEAD_BEEF,32'h44, 0,32'h40,1, 32'h40,0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,0,1,0,32'h0,        32'h44, 1,32'h40,1, 32'h40,0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,1,0,1,32'h3333_3333,32'h80, 0,32'h40,0, 32'h80,0,32'h1111_1111,32'h8));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,32'h0,      32'h84, 1,32'h80,1, 32'h80,0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,0,1,0,32'h0,        32'h84, 1,32'h80,1, 32'h80,0,32'h1111_1111,32'h8));
    vecs.push_back(mk(0,0,0,1,32'h2222_2222,32'h84, 0,32'h80,0, 32'h84,1,32'h2222_2222,32'h84));
    vecs.push_back(mk(0,0,1,0,32'h0,        32'h88, 1,32'h84,1, 32'h84,0,32'h2222_2222,32'h84));

    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      stall = vecs[i].stall; redirect = vecs[i].redirect;
      imem_ready = vecs[i].ready; imem_rvalid = vecs[i].rvalid;
      imem_rdata = vecs[i].rdata; pc_next = vecs[i].pc_next;
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_busy", i), 32'(fetch_busy), 32'(vecs[i].e_busy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i), if_id_pc4, vecs[i].e_pc4);
    end

    // Asynchronous reset while a request is outstanding (last vector left the stage in S_WAIT).
    @(negedge clk);
    stall = 0; redirect = 0; imem_ready = 0; imem_rvalid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", 32'(if_id_valid), 32'h0);
    chk("mid_rst_instr", if_id_instr, 32'h0);
    chk("mid_rst_pc4", if_id_pc4, 32'h0);
    chk("mid_rst_req", 32'(imem_req), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Random run against the reference model, starting from the reset state.
    m_pc = 32'h0; m_out = 0; m_kill = 0; m_held.delete();
    e_valid = 0; e_instr = 32'h0; e_pc4 = 32'h0;
    mem_pend = 0; mem_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("rnd_valid", 32'(if_id_valid), 32'(e_valid));
      if (e_valid) begin
        chk("rnd_instr", if_id_instr, e_instr);
        chk("rnd_pc4", if_id_pc4, e_pc4);
      end
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      imem_ready  = m_req() && ($urandom_range(0, 1) == 1);
      imem_rvalid = mem_pend && (mem_cnt == 0);
      imem_rdata  = $urandom;
      pc_next = redirect ? {22'h0, 8'($urandom_range(0, 255)), 2'b00} : m_pc + 32'd4;
      #1;
      chk("rnd_req", 32'(imem_req), 32'(m_req()));
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_busy", 32'(fetch_busy),
          32'((m_held.size() == 0) && !(m_out && imem_rvalid && !m_kill)));
      @(posedge clk);
      if (imem_rvalid) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (imem_ready && m_req()) begin
        mem_pend = 1;
        mem_cnt  = $urandom_range(0, 3);
      end
      m_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
